// File: rtl/peripheral_spram_ahb4_ws.sv
// peripheral_spram_ahb4_ws: parametrised AHB-Lite single-port RAM slave with byte lanes,
// programmable wait states, optional registered read data, write forwarding and ERROR responses.
`default_nettype none

module peripheral_spram_ahb4_ws #(
  parameter int PLEN              = 16,
  parameter int XLEN              = 32,
  parameter int MEM_DEPTH         = 256,
  parameter int WAIT_STATES       = 0,
  parameter int REGISTERED_OUTPUT = 0
) (
  input  logic            HRESETn,
  input  logic            HCLK,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int BYTES = XLEN / 8;
  localparam int ABITS = $clog2(BYTES);
  localparam int IDXW  = PLEN - ABITS;
  localparam int MAW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic            launch;

  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [XLEN-1:0] rd_buf;
  logic [XLEN-1:0] hrdata_q;

  logic            dp_write, dp_read;
  logic [MAW-1:0]  dp_idx;
  logic [BYTES-1:0] dp_mask;

  logic [IDXW-1:0]  word_idx;
  logic [ABITS-1:0] acc_off;
  logic [MAW-1:0]   acc_idx;
  logic [BYTES-1:0] acc_mask;
  logic             misalign, size_ok, range_ok, legal, accept;
  logic [CW-1:0]    load;
  logic             wr_commit, rd_issue, fwd_hit;

  // BUSY/IDLE transfers and HBURST play no part: the master supplies every address.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign word_idx = HADDR[PLEN-1:ABITS];
  assign acc_off  = HADDR[ABITS-1:0];
  assign acc_idx  = word_idx[MAW-1:0];
  assign size_ok  = (HSIZE <= 3'(ABITS));
  assign range_ok = ({{(64-IDXW){1'b0}}, word_idx} < 64'(MEM_DEPTH));
  assign legal    = size_ok && !misalign && range_ok;
  assign accept   = HSEL && HREADY && HTRANS[1];
  assign load     = CW'(WAIT_STATES) + CW'((REGISTERED_OUTPUT != 0) && !HWRITE);

  always_comb begin
    acc_mask = '0;
    misalign = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(acc_off) && b < int'(acc_off) + (1 << HSIZE)) acc_mask[b] = 1'b1;
    end
    for (int i = 0; i < ABITS; i++) begin
      if (i < int'(HSIZE) && HADDR[i]) misalign = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    launch     = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        HRESP      = (state == ST_ERR2);
        next_state = ST_IDLE;
        next_cnt   = '0;
        if (accept) begin
          launch = 1'b1;
          if (!legal) begin
            next_state = ST_ERR1;
          end else if (load == '0) begin
            next_state = ST_DATA;
          end else begin
            next_state = ST_WAIT;
            next_cnt   = load - CW'(1);
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == '0) next_state = ST_DATA;
        else           next_cnt   = cnt - CW'(1);
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        next_state = ST_ERR2;
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_write <= 1'b0;
      dp_read  <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
    end else if (launch) begin
      dp_write <= HWRITE && legal;
      dp_read  <= !HWRITE && legal;
      dp_idx   <= acc_idx;
      dp_mask  <= acc_mask;
    end
  end

  // Writes commit on the single HREADYOUT-high cycle; state is reset asynchronously,
  // so a transfer cut short by reset never reaches this edge.
  assign wr_commit = (state == ST_DATA) && dp_write;
  assign rd_issue  = launch && legal && !HWRITE;
  assign fwd_hit   = wr_commit && (dp_idx == acc_idx);

  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dp_mask[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
    if (rd_issue) begin
      for (int b = 0; b < BYTES; b++) begin
        rd_buf[8*b +: 8] <= (fwd_hit && dp_mask[b]) ? HWDATA[8*b +: 8] : mem[acc_idx][8*b +: 8];
      end
    end
  end

  generate
    if (REGISTERED_OUTPUT != 0) begin : g_regout
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                                       hrdata_q <= '0;
        else if (state == ST_WAIT && cnt == '0 && dp_read)  hrdata_q <= rd_buf;
      end
      assign HRDATA = hrdata_q;
    end else begin : g_combout
      // The hold register keeps the last completed read visible between reads.
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                          hrdata_q <= '0;
        else if (state == ST_DATA && dp_read)  hrdata_q <= rd_buf;
      end
      assign HRDATA = (state == ST_DATA && dp_read) ? rd_buf : hrdata_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_peripheral_spram_ahb4_ws.sv
// tb_peripheral_spram_ahb4_ws: table-driven pipelined AHB master with an expected-response queue,
// exercising a zero-wait instance and a WAIT_STATES=2 / REGISTERED_OUTPUT=1 instance.
`default_nettype none

module tb_peripheral_spram_ahb4_ws;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        hsel, hwrite, hmastlock;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [3:0]  hprot;
  int          sel = 0;

  logic [31:0] rdata0, rdata1, hrdata_m;
  logic        rdyo0, rdyo1, resp0, resp1, hready, hresp_m, hsel0, hsel1;

  assign hsel0    = hsel && (sel == 0);
  assign hsel1    = hsel && (sel == 1);
  assign hready   = (sel == 1) ? rdyo1 : rdyo0;
  assign hresp_m  = (sel == 1) ? resp1 : resp0;
  assign hrdata_m = (sel == 1) ? rdata1 : rdata0;

  peripheral_spram_ahb4_ws #(.PLEN(16), .XLEN(32), .MEM_DEPTH(256), .WAIT_STATES(0), .REGISTERED_OUTPUT(0)) dut0 (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata0),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(rdyo0), .HRESP(resp0));

  peripheral_spram_ahb4_ws #(.PLEN(16), .XLEN(32), .MEM_DEPTH(256), .WAIT_STATES(2), .REGISTERED_OUTPUT(1)) dut1 (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata1),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(rdyo1), .HRESP(resp1));

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic        resp;
    int          waits;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SGL = 3'd0, B_INCR4 = 3'd3;

  function automatic void add(input logic [1:0] t, input logic w, input logic [2:0] sz,
                              input logic [2:0] bu, input logic [15:0] a, input logic [31:0] d,
                              input logic er, input logic cr, input logic [31:0] rd);
    vec_t v;
    v.trans = t; v.write = w; v.size = sz; v.burst = bu; v.addr = a; v.wdata = d;
    v.exp_resp = er; v.chk_rd = cr; v.exp_rd = rd;
    tbl.push_back(v);
  endfunction

  // Expected HREADYOUT-low cycles: dut1 has WAIT_STATES=2 plus one extra cycle on reads.
  function automatic int exp_waits(input int s, input vec_t v);
    if (!v.trans[1]) return 0;
    if (v.exp_resp)  return 1;
    if (s == 1)      return v.write ? 2 : 3;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_seq(input int s, input int lo, input int hi);
    int   i, waits, cyc;
    bit   dpv;
    vec_t dp;
    logic rdy;
    exp_t e;
    i = lo; dpv = 1'b0; waits = 0; cyc = 0;
    sel = s;
    @(posedge HCLK); #1;
    while (i < hi || dpv) begin
      hsel = 1'b1;
      if (i < hi) begin
        htrans = tbl[i].trans; hwrite = tbl[i].write; hsize = tbl[i].size;
        hburst = tbl[i].burst; haddr = tbl[i].addr;
      end else begin
        htrans = T_IDLE;
      end
      hwdata = (dpv && dp.write) ? dp.wdata : 32'h0;
      @(negedge HCLK);
      rdy = hready;
      if (dpv) begin
        if (!rdy) begin
          waits++;
        end else if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard empty at vector block %0d", lo);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d resp", e.idx), {31'b0, hresp_m}, {31'b0, e.resp});
          chk($sformatf("v%0d waits", e.idx), 32'(waits), 32'(e.waits));
          if (e.chk_rd) chk($sformatf("v%0d rdata", e.idx), hrdata_m, e.rd);
        end
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        waits = 0;
        if (i < hi) begin
          e.idx = i; e.resp = tbl[i].exp_resp; e.waits = exp_waits(s, tbl[i]);
          e.chk_rd = tbl[i].chk_rd; e.rd = tbl[i].exp_rd;
          sb.push_back(e);
          dp = tbl[i]; dpv = 1'b1; i++;
        end else begin
          dpv = 1'b0;
        end
      end
      cyc++;
      if (cyc > 400) begin
        n_checks++; n_fail++;
        $display("FAIL timeout in vector block %0d", lo);
        i = hi; dpv = 1'b0;
      end
    end
    hsel = 1'b0;
    htrans = T_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi;
    hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; hsize = 3'd2; hburst = B_SGL;
    htrans = T_IDLE; hprot = 4'h3; hmastlock = 1'b0;

    // Zero-wait instance: forwarding, byte lanes, errors, top word, IDLE hold
    a_lo = tbl.size();
    add(T_NS, 1, 3'd2, B_SGL, 16'h0010, 32'hDEADBEEF, 0, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0010, 32'h0,        0, 1, 32'hDEADBEEF);
    add(T_NS, 1, 3'd2, B_SGL, 16'h0020, 32'h11223344, 0, 0, 32'h0);
    add(T_NS, 1, 3'd0, B_SGL, 16'h0022, 32'h00AA0000, 0, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0020, 32'h0,        0, 1, 32'h11AA3344);
    add(T_NS, 1, 3'd1, B_SGL, 16'h0020, 32'h00005566, 0, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0020, 32'h0,        0, 1, 32'h11AA5566);
    add(T_NS, 1, 3'd2, B_SGL, 16'h0400, 32'hFFFFFFFF, 1, 1, 32'h11AA5566);
    add(T_NS, 1, 3'd1, B_SGL, 16'h0001, 32'hFFFFFFFF, 1, 0, 32'h0);
    add(T_NS, 1, 3'd3, B_SGL, 16'h0020, 32'hFFFFFFFF, 1, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0020, 32'h0,        0, 1, 32'h11AA5566);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0400, 32'h0,        1, 1, 32'h11AA5566);
    add(T_NS, 1, 3'd2, B_SGL, 16'h03FC, 32'hCAFEF00D, 0, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h03FC, 32'h0,        0, 1, 32'hCAFEF00D);
    add(T_NS, 0, 3'd0, B_SGL, 16'h0013, 32'h0,        0, 1, 32'hDEADBEEF);
    add(T_IDLE, 0, 3'd2, B_SGL, 16'h0000, 32'h0,      0, 1, 32'hDEADBEEF);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0010, 32'h0,        0, 1, 32'hDEADBEEF);
    a_hi = tbl.size();

    // INCR4 write and read bursts with a BUSY beat inside each
    b_lo = tbl.size();
    add(T_NS,   1, 3'd2, B_INCR4, 16'h0040, 32'h10000040, 0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, B_INCR4, 16'h0044, 32'h10000044, 0, 0, 32'h0);
    add(T_BUSY, 1, 3'd2, B_INCR4, 16'h0048, 32'h0,        0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, B_INCR4, 16'h0048, 32'h10000048, 0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, B_INCR4, 16'h004C, 32'h1000004C, 0, 0, 32'h0);
    add(T_NS,   0, 3'd2, B_INCR4, 16'h0040, 32'h0,        0, 1, 32'h10000040);
    add(T_SEQ,  0, 3'd2, B_INCR4, 16'h0044, 32'h0,        0, 1, 32'h10000044);
    add(T_BUSY, 0, 3'd2, B_INCR4, 16'h0048, 32'h0,        0, 1, 32'h10000044);
    add(T_SEQ,  0, 3'd2, B_INCR4, 16'h0048, 32'h0,        0, 1, 32'h10000048);
    add(T_SEQ,  0, 3'd2, B_INCR4, 16'h004C, 32'h0,        0, 1, 32'h1000004C);
    b_hi = tbl.size();

    // Wait-state instance
    c_lo = tbl.size();
    add(T_NS, 1, 3'd2, B_SGL, 16'h0010, 32'h12345678, 0, 0, 32'h0);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0010, 32'h0,        0, 1, 32'h12345678);
    add(T_NS, 1, 3'd2, B_SGL, 16'h0030, 32'h0BADF00D, 0, 0, 32'h0);
    add(T_NS, 1, 3'd0, B_SGL, 16'h0031, 32'h0000EE00, 0, 0, 32'h0);
    add(T_NS, 0, 3'd0, B_SGL, 16'h0031, 32'h0,        0, 1, 32'h0BADEE0D);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0400, 32'h0,        1, 1, 32'h0BADEE0D);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0002, 32'h0,        1, 1, 32'h0BADEE0D);
    c_hi = tbl.size();

    // Readback after the interrupted write
    d_lo = tbl.size();
    add(T_NS, 0, 3'd2, B_SGL, 16'h0010, 32'h0, 0, 1, 32'h12345678);
    add(T_NS, 0, 3'd2, B_SGL, 16'h0030, 32'h0, 0, 1, 32'h0BADEE0D);
    d_hi = tbl.size();

    #12;
    chk("reset hreadyout", {31'b0, rdyo0}, 32'd1);
    chk("reset hresp",     {31'b0, resp0}, 32'd0);
    chk("reset hrdata",    rdata0,         32'h0);
    chk("reset hreadyout1", {31'b0, rdyo1}, 32'd1);
    #11 HRESETn = 1'b1;

    run_seq(0, a_lo, a_hi);
    run_seq(0, b_lo, b_hi);
    run_seq(1, c_lo, c_hi);

    // Reset in the middle of a waited write must drop the write
    sel = 1;
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = T_NS; hwrite = 1'b1; hsize = 3'd2; hburst = B_SGL; haddr = 16'h0010;
    @(posedge HCLK); #1;
    htrans = T_IDLE; hwdata = 32'hFFFFFFFF;
    #2;
    chk("inflight hreadyout", {31'b0, rdyo1}, 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("async hreadyout", {31'b0, rdyo1}, 32'd1);
    chk("async hresp",     {31'b0, resp1}, 32'd0);
    chk("async hrdata1",   rdata1,         32'h0);
    chk("async hrdata0",   rdata0,         32'h0);
    #31 HRESETn = 1'b1;
    hsel = 1'b0;

    run_seq(1, d_lo, d_hi);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/peripheral_spram_ahb4_ws.md
# peripheral_spram_ahb4_ws

Parametrised AHB-Lite single-port RAM slave, successor to the fixed-configuration SPRAM peripheral. Adds configurable data width and depth, HSIZE byte-lane writes, programmable wait states, optional registered read data, write-to-read forwarding, and two-cycle ERROR responses for illegal or out-of-range accesses. Sits on an AHB4 interconnect slave port in the MPSoC peripheral library.

## Interface
- PLEN, 16: HADDR width (byte address).
- XLEN, 32: data width; 32 or 64.
- MEM_DEPTH, 256: number of XLEN-wide words.
- WAIT_STATES, 0: extra HREADYOUT-low cycles per transfer (0..15).
- REGISTERED_OUTPUT, 0: 1 adds one read-only wait cycle; HRDATA driven from a flop.
- HRESETn  in  1  asynchronous active-low reset.
- HCLK  in  1  clock; all logic rising-edge.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address.
- HWDATA  in  XLEN  write data (data phase).
- HRDATA  out  XLEN  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; addresses taken from HADDR, not generated internally.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus ready (from interconnect).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]; controls latched. IDLE/BUSY or HSEL=0: zero-wait OKAY, no access.
- Legality: HSIZE ≤ log2(XLEN/8), HADDR aligned to size, word index HADDR>>log2(XLEN/8) < MEM_DEPTH. Otherwise ERROR; memory untouched.
- Byte lanes: mask of 2^HSIZE bytes starting at HADDR[log2(XLEN/8)-1:0], little-endian.
- Write: HWDATA sampled on last data-phase cycle (HREADYOUT=1); masked lanes written at that edge.
- Read: array read synchronous; full word returned on HRDATA, master selects lanes.
- Forwarding: read whose address phase overlaps the final cycle of a write data phase to the same word returns merged data (new bytes in written lanes, old elsewhere).
- FSM: IDLE → WAIT (counter loaded with WAIT_STATES + REGISTERED_OUTPUT·read, minus 1) → DATA → IDLE or next WAIT/DATA on back-to-back accept. Zero count: IDLE → DATA directly. Illegal: IDLE → ERR1 → ERR2 → IDLE.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Address phase presented during ERR2 is accepted normally.
- Memory contents not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM IDLE, wait counter 0.
- Reset asserted mid-transfer: FSM to IDLE at once; uncommitted write discarded.
- Read latency: data valid in data phase after WAIT_STATES + REGISTERED_OUTPUT low cycles; 0/0 gives single-cycle data phase.
- Write data phase: WAIT_STATES low cycles, then one high cycle.
- HRDATA holds last read value until the next read completes; unchanged by writes and errors.
- Back-to-back zero-wait accesses sustain one transfer per cycle, including write followed by read of the same word.
- HREADY low (other slave stalling): no new address phase accepted; in-progress state unaffected.

## Test plan
- Reset: HRESETn low 32 ns mid-clock → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; write in flight not committed (readback shows prior value).
- WAIT_STATES=0, REGISTERED_OUTPUT=0: write 0xDEADBEEF to 0x0010, read 0x0010 next cycle → 0xDEADBEEF via forwarding, HREADYOUT never low.
- Byte write: word 0x0020 = 0x11223344; HSIZE=0 write 0xAA at 0x0022 → read 0x11AA3344; HSIZE=1 write 0x5566 at 0x0020 → 0x11AA5566.
- WAIT_STATES=2, REGISTERED_OUTPUT=1: read → HREADYOUT low 3 cycles; write → low 2 cycles; data correct.
- Errors: address 0x0400 (word 256), HSIZE=1 at 0x0001, HSIZE=3 with XLEN=32 → each gives ERR1/ERR2 sequence, memory unchanged on readback.
- INCR4 burst of SEQ writes 0x0040..0x004C then INCR4 reads, with one BUSY inserted → data matches, BUSY gets zero-wait OKAY.
